// File: rtl/serial_cmd_parser.sv
// serial_cmd_parser: frames UART bytes (SYNC, ADDR, LEN, payload, CHK) into
// register writes. Payload is buffered and only written out once CHK matches.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rx_data, rx_new     received byte and its one-cycle strobe
//   wr_en/addr/data     register write port, one write per cycle
//   frame_done          one-cycle pulse, frame committed
//   frame_err           one-cycle pulse, frame dropped
//   err_code            0 none, 1 checksum, 2 length, 3 timeout (held)
//   busy                high whenever the parser is not idle
module serial_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_new,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       frame_done,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    MAX_L  = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_PAYLOAD,
        S_CHECK,
        S_COMMIT
    } state_t;

    state_t        state;
    logic [7:0]    base;
    logic [7:0]    len;
    logic [7:0]    idx;
    logic [7:0]    chk;
    logic [TW-1:0] tcnt;
    logic [7:0]    mem [MAX_LEN];

    logic in_frame;
    logic timeout;

    assign in_frame = (state == S_ADDR) || (state == S_LEN) ||
                      (state == S_PAYLOAD) || (state == S_CHECK);
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign timeout  = in_frame && !rx_new && (tcnt == T_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            base       <= '0;
            len        <= '0;
            idx        <= '0;
            chk        <= '0;
            tcnt       <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            err_code   <= '0;
            busy       <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            if (rx_new || !in_frame)
                tcnt <= '0;
            else
                tcnt <= tcnt + TW'(1);

            if (timeout) begin
                frame_err <= 1'b1;
                err_code  <= 2'd3;
                state     <= S_IDLE;
                busy      <= 1'b0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (rx_new && rx_data == SYNC_BYTE) begin
                            state <= S_ADDR;
                            busy  <= 1'b1;
                        end
                    end
                    S_ADDR: begin
                        if (rx_new) begin
                            base  <= rx_data;
                            chk   <= rx_data;
                            state <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (rx_new) begin
                            len <= rx_data;
                            chk <= chk ^ rx_data;
                            idx <= '0;
                            if (rx_data > MAX_L) begin
                                frame_err <= 1'b1;
                                err_code  <= 2'd2;
                                state     <= S_IDLE;
                                busy      <= 1'b0;
                            end else if (rx_data == 8'd0) begin
                                state <= S_CHECK;
                            end else begin
                                state <= S_PAYLOAD;
                            end
                        end
                    end
                    S_PAYLOAD: begin
                        if (rx_new) begin
                            mem[idx[IW-1:0]] <= rx_data;
                            chk <= chk ^ rx_data;
                            idx <= idx + 8'd1;
                            if (idx == len - 8'd1)
                                state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (rx_new) begin
                            if (rx_data != chk) begin
                                frame_err <= 1'b1;
                                err_code  <= 2'd1;
                                state     <= S_IDLE;
                                busy      <= 1'b0;
                            end else if (len == 8'd0) begin
                                frame_done <= 1'b1;
                                err_code   <= 2'd0;
                                state      <= S_IDLE;
                                busy       <= 1'b0;
                            end else begin
                                // First write issues on the CHK cycle so
                                // writes line up with error/done timing.
                                wr_en   <= 1'b1;
                                wr_addr <= base;
                                wr_data <= mem[0];
                                idx     <= 8'd1;
                                if (len == 8'd1) begin
                                    frame_done <= 1'b1;
                                    err_code   <= 2'd0;
                                    state      <= S_IDLE;
                                    busy       <= 1'b0;
                                end else begin
                                    state <= S_COMMIT;
                                end
                            end
                        end
                    end
                    S_COMMIT: begin
                        wr_en   <= 1'b1;
                        wr_addr <= base + idx;
                        wr_data <= mem[idx[IW-1:0]];
                        idx     <= idx + 8'd1;
                        if (idx == len - 8'd1) begin
                            frame_done <= 1'b1;
                            err_code   <= 2'd0;
                            state      <= S_IDLE;
                            busy       <= 1'b0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
